dmem_wbuf: RTL and testbench



---
 rtl/dmem_wbuf_pkg.sv | 17 +
 rtl/dmem_wbuf_if.sv | 29 ++
 rtl/dmem_wbuf_match.sv | 39 +++
 rtl/dmem_wbuf.sv | 90 +++++++++
 tb/tb_dmem_wbuf.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_wbuf_pkg.sv
// Shared default widths and entry types for the data-memory store buffer.
// Used by dmem_wbuf (load forwarding selected with WBUF_FWD_EN).
package dmem_pkg;

    localparam int unsigned DMEM_WORD_W = 8;
    localparam int unsigned DMEM_OP_W   = 3;
    localparam int unsigned DMEM_ADDR_W = DMEM_WORD_W - DMEM_OP_W;

    typedef logic [DMEM_ADDR_W-1:0] addr_t;
    typedef logic [DMEM_WORD_W-1:0] word_t;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf_if.sv
// CPU-side store/load bus of the store buffer (WBUF_FWD_EN changes only the
// ld_ready/ld_data behaviour, not the signal set).
interface dmem_wbuf_if
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_W = DMEM_WORD_W,
    parameter int unsigned OP_W   = DMEM_OP_W
);

    logic                   st_valid;
    logic                   st_ready;
    logic [WORD_W-OP_W-1:0] st_addr;
    logic [WORD_W-1:0]      st_data;
    logic                   ld_req;
    logic [WORD_W-OP_W-1:0] ld_addr;
    logic                   ld_ready;
    logic [WORD_W-1:0]      ld_data;

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr,
        input  st_ready, ld_ready, ld_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr,
        output st_ready, ld_ready, ld_data
    );

endinterface

// File: rtl/dmem_wbuf_match.sv
// Load-forwarding lookup: DEPTH-way address compare, youngest entry wins.
// Built only when WBUF_FWD_EN is defined.
`ifdef WBUF_FWD_EN
module wbuf_match
    import dmem_pkg::*;
#(
    parameter int unsigned AW    = DMEM_ADDR_W,
    parameter int unsigned DW    = DMEM_WORD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0][AW-1:0] buf_addr,
    input  logic [DEPTH-1:0][DW-1:0] buf_data,
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            ld_addr,
    output logic                     hit,
    output logic [DW-1:0]            hit_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < count) && (buf_addr[idx] == ld_addr)) begin
                hit      = 1'b1;
                hit_data = buf_data[idx];
            end
        end
    end

endmodule
`endif

// File: rtl/dmem_wbuf.sv
// In-order store buffer in front of the data memory port. Define WBUF_FWD_EN
// to give loads port priority with forwarding; otherwise loads wait for empty.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_W = DMEM_WORD_W,
    parameter int unsigned OP_W   = DMEM_OP_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   n_reset,
    dmem_wbuf_if.slave             cpu,
    output logic [WORD_W-OP_W-1:0] Daddress,
    output logic [WORD_W-1:0]      Wdata,
    output logic                   WE,
    input  logic [WORD_W-1:0]      Mdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = WORD_W - OP_W;
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0][AW-1:0]     buf_addr;
    logic [DEPTH-1:0][WORD_W-1:0] buf_data;
    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic                         push;
    logic                         drain;
    logic                         ld_own;

    assign cpu.st_ready = (count != (PW+1)'(DEPTH));
    assign push         = cpu.st_valid && cpu.st_ready;

`ifdef WBUF_FWD_EN
    logic              hit;
    logic [WORD_W-1:0] hit_data;

    wbuf_match #(
        .AW    (AW),
        .DW    (WORD_W),
        .DEPTH (DEPTH)
    ) u_match (
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .head     (head),
        .count    (count),
        .ld_addr  (cpu.ld_addr),
        .hit      (hit),
        .hit_data (hit_data)
    );

    assign cpu.ld_ready = 1'b1;
    assign ld_own       = n_reset && cpu.ld_req;
    assign cpu.ld_data  = hit ? hit_data : Mdata;
`else
    assign cpu.ld_ready = (count == '0);
    assign ld_own       = n_reset && cpu.ld_req && cpu.ld_ready;
    assign cpu.ld_data  = Mdata;
`endif

    assign drain    = (count != '0) && !ld_own;
    assign WE       = drain;
    assign Daddress = ld_own ? cpu.ld_addr : buf_addr[head];
    assign Wdata    = buf_data[head];

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            if (push) begin
                buf_addr[tail] <= cpu.st_addr;
                buf_data[tail] <= cpu.st_data;
                tail           <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            if (push && !drain) begin
                count <= count + 1'b1;
            end else if (drain && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: queue-based reference model checked every
// cycle, plus directed literal checks; follows WBUF_FWD_EN like the design.
module tb_dmem_wbuf;
    import dmem_pkg::*;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned AW     = WORD_W - OP_W;
    localparam int unsigned DEPTH  = 4;

    logic              clock   = 1'b0;
    logic              n_reset = 1'b0;
    logic [AW-1:0]     Daddress;
    logic [WORD_W-1:0] Wdata;
    logic              WE;
    logic [WORD_W-1:0] Mdata;
    logic [2:0]        count;

    dmem_wbuf_if #(.WORD_W(WORD_W), .OP_W(OP_W)) cpu ();

    dmem_wbuf #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .cpu      (cpu),
        .Daddress (Daddress),
        .Wdata    (Wdata),
        .WE       (WE),
        .Mdata    (Mdata),
        .count    (count)
    );

    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment data memory, preloaded with 0x40+addr.
    logic [WORD_W-1:0] mem [32];
    logic              mem_ready = 1'b0;
    assign Mdata = mem[Daddress];
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h40 + i);
            mem_ready <= 1'b1;
        end else if (WE) begin
            mem[Daddress] <= Wdata;
        end
    end

    // Reference model: FIFO of pending stores and the memory image they produce.
    wbuf_entry_t       q[$];
    logic [WORD_W-1:0] ref_mem [32];
    bit                ref_ready = 1'b0;

    function automatic bit exp_we();
`ifdef WBUF_FWD_EN
        return (q.size() != 0) && !cpu.ld_req;
`else
        return q.size() != 0;
`endif
    endfunction

    function automatic logic [WORD_W-1:0] exp_load(input logic [AW-1:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr == a) return q[i].data;
        return ref_mem[a];
    endfunction

    always @(posedge clock or negedge n_reset) begin
        bit          drn;
        bit          psh;
        wbuf_entry_t e;
        if (!ref_ready) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = 8'(8'h40 + i);
            ref_ready = 1'b1;
        end
        if (!n_reset) begin
            q.delete();
        end else begin
            drn    = exp_we();
            psh    = cpu.st_valid && (q.size() < DEPTH);
            e.addr = cpu.st_addr;
            e.data = cpu.st_data;
            if (drn) begin
                ref_mem[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
            if (psh) q.push_back(e);
        end
    end

    always @(negedge clock) begin
        int n;
        if (!n_reset) begin
            check("rst_count", 32'(count), 0);
            check("rst_we", 32'(WE), 0);
            check("rst_st_ready", 32'(cpu.st_ready), 1);
            check("rst_daddress", 32'(Daddress), 0);
            check("rst_wdata", 32'(Wdata), 0);
            check("rst_ld_ready", 32'(cpu.ld_ready), 1);
        end else if (ref_ready) begin
            n = q.size();
            check("count", 32'(count), 32'(n));
            check("st_ready", 32'(cpu.st_ready), 32'(n != DEPTH));
            check("we", 32'(WE), 32'(exp_we()));
            if (exp_we()) begin
                check("drain_daddress", 32'(Daddress), 32'(q[0].addr));
                check("drain_wdata", 32'(Wdata), 32'(q[0].data));
            end
`ifdef WBUF_FWD_EN
            check("ld_ready", 32'(cpu.ld_ready), 1);
            if (cpu.ld_req) begin
                check("ld_daddress", 32'(Daddress), 32'(cpu.ld_addr));
                check("ld_data", 32'(cpu.ld_data), 32'(exp_load(cpu.ld_addr)));
            end
`else
            check("ld_ready", 32'(cpu.ld_ready), 32'(n == 0));
            if (n == 0 && cpu.ld_req) begin
                check("ld_daddress", 32'(Daddress), 32'(cpu.ld_addr));
                check("ld_data", 32'(cpu.ld_data), 32'(ref_mem[cpu.ld_addr]));
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [WORD_W-1:0] d);
        cpu.st_valid = 1'b1;
        cpu.st_addr  = a;
        cpu.st_data  = d;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [WORD_W-1:0] d);
        drive(a, d);
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (cpu.st_ready) begin
                tick();
                cpu.st_valid = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL store_timeout: addr 0x%0h never accepted, required within 64 cycles", a);
        cpu.st_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        cpu.st_valid = 1'b0;
        cpu.st_addr  = '0;
        cpu.st_data  = '0;
        cpu.ld_req   = 1'b0;
        cpu.ld_addr  = '0;
        repeat (3) @(posedge clock);
        #1 n_reset = 1'b1;
        tick();

        // Two back-to-back stores drain on consecutive cycles.
        drive(5'd3, 8'hA1);
        tick();
        drive(5'd7, 8'hB2);
        @(negedge clock);
        check("t1_we", 32'(WE), 1);
        check("t1_daddress", 32'(Daddress), 3);
        check("t1_wdata", 32'(Wdata), 32'hA1);
        tick();
        cpu.st_valid = 1'b0;
        @(negedge clock);
        check("t2_we", 32'(WE), 1);
        check("t2_daddress", 32'(Daddress), 7);
        check("t2_wdata", 32'(Wdata), 32'hB2);
        tick();
        @(negedge clock);
        check("t3_we", 32'(WE), 0);
        check("t3_count", 32'(count), 0);
        check("mem3", 32'(mem[3]), 32'hA1);
        check("mem7", 32'(mem[7]), 32'hB2);
        tick();

`ifdef WBUF_FWD_EN
        // Forwarding: youngest match wins, miss reads memory.
        cpu.ld_req  = 1'b1;
        cpu.ld_addr = 5'd0;
        store(5'd5, 8'h11);
        store(5'd5, 8'h22);
        cpu.ld_addr = 5'd5;
        @(negedge clock);
        check("fwd_ld_ready", 32'(cpu.ld_ready), 1);
        check("fwd_ld_data", 32'(cpu.ld_data), 32'h22);
        check("fwd_we_stall", 32'(WE), 0);
        tick();
        cpu.ld_addr = 5'd6;
        @(negedge clock);
        check("fwd_miss_data", 32'(cpu.ld_data), 32'h46);
        tick();
        // Push and drain on one edge at count 2.
        cpu.ld_req = 1'b0;
        drive(5'd8, 8'h33);
        tick();
        cpu.st_valid = 1'b0;
        @(negedge clock);
        check("pushdrain_count", 32'(count), 2);
        repeat (3) tick();
        check("mem5", 32'(mem[5]), 32'h22);
        check("mem8", 32'(mem[8]), 32'h33);

        // Full buffer holds a fifth store until loads release the port.
        cpu.ld_req  = 1'b1;
        cpu.ld_addr = 5'd1;
        fork
            begin
                for (int i = 0; i < 5; i++) store(5'(20 + i), 8'(8'h60 + i));
            end
            begin
                repeat (4) tick();
                @(negedge clock);
                check("full_count", 32'(count), 4);
                check("full_st_ready", 32'(cpu.st_ready), 0);
                repeat (3) tick();
                @(negedge clock);
                check("full_held_count", 32'(count), 4);
                tick();
                cpu.ld_req = 1'b0;
            end
        join
        repeat (6) tick();
        for (int i = 0; i < 5; i++) check("full_mem", 32'(mem[20 + i]), 32'(8'h60 + i));
`else
        // Loads wait for the buffer to empty.
        drive(5'd5, 8'h55);
        tick();
        drive(5'd9, 8'h99);
        cpu.ld_req  = 1'b1;
        cpu.ld_addr = 5'd5;
        @(negedge clock);
        check("wait1_ld_ready", 32'(cpu.ld_ready), 0);
        tick();
        cpu.st_valid = 1'b0;
        @(negedge clock);
        check("wait2_ld_ready", 32'(cpu.ld_ready), 0);
        tick();
        @(negedge clock);
        check("wait3_ld_ready", 32'(cpu.ld_ready), 1);
        check("wait3_ld_data", 32'(cpu.ld_data), 32'h55);
        tick();
        cpu.ld_req = 1'b0;
        tick();
        check("mem9", 32'(mem[9]), 32'h99);
`endif

        // Pointer wrap over 3*DEPTH stores with interleaved loads; order kept.
        cpu.ld_addr = 5'd18;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) store(5'(16 + i % 6), 8'(8'hC0 + i));
            end
            begin
                repeat (6) begin
                    cpu.ld_req = 1'b1;
                    repeat (2) tick();
                    cpu.ld_req = 1'b0;
                    tick();
                end
            end
        join
        cpu.ld_req = 1'b0;
        repeat (6) tick();
        for (int k = 0; k < 6; k++) check("wrap_mem", 32'(mem[16 + k]), 32'(8'hC6 + k));

        // Reset with stores pending discards them.
`ifdef WBUF_FWD_EN
        cpu.ld_req  = 1'b1;
        cpu.ld_addr = 5'd0;
        store(5'd10, 8'hD0);
        store(5'd11, 8'hD1);
        store(5'd12, 8'hD2);
        check("pre_rst_count", 32'(count), 3);
`else
        store(5'd10, 8'hD0);
        check("pre_rst_count", 32'(count), 1);
`endif
        cpu.ld_req = 1'b0;
        n_reset    = 1'b0;
        #1;
        check("mid_rst_we", 32'(WE), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_st_ready", 32'(cpu.st_ready), 1);
        repeat (2) tick();
        n_reset = 1'b1;
        repeat (3) tick();
        check("rst_mem10", 32'(mem[10]), 32'h4A);
        check("rst_mem11", 32'(mem[11]), 32'h4B);
        check("rst_mem12", 32'(mem[12]), 32'h4C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
